// File: rtl/lookup3_pkg.sv
// lookup3_pkg
// Shared constants, state encoding and rotate helper for the lookup3
// block mixer.
//   INIT_WORD   : constant folded into the initial a/b/c
//   BLOCK_BYTES : bytes consumed per mixed block
//   ROT_AMT     : rotate amount of each of the six mix lines, in order
//   state_t     : controller states of lookup3_block_mixer
//   rotl()      : 32-bit rotate left, amount 1..31
package lookup3_pkg;

   localparam logic [31:0] INIT_WORD   = 32'hDEADBEEF;
   localparam int          BLOCK_BYTES = 12;

   localparam logic [4:0] ROT_AMT [0:5] = '{5'd4, 5'd6, 5'd8, 5'd16, 5'd19, 5'd4};

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      ADD,
      MIX,
      OUT
   } state_t;

   // Rotate amount is never zero in this design, so the right shift by
   // (32 - k) always stays below the word width.
   function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] k);
      return (x << k) | (x >> (6'd32 - {1'b0, k}));
   endfunction

endpackage

// File: rtl/lookup3_mix_step.sv
// lookup3_mix_step
// Combinational single line of the lookup3 mix() macro. One instance is
// stepped through six cycles by the controller.
// Ports:
//   a, b, c                : current hash state
//   step                   : mix line to apply, 0..5 (6/7 pass through)
//   a_next, b_next, c_next : state after that line
module lookup3_mix_step
   import lookup3_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [31:0] c,
   input  logic [2:0]  step,
   output logic [31:0] a_next,
   output logic [31:0] b_next,
   output logic [31:0] c_next
);

   // The six lines rotate through three shapes (a by c, b by a, c by b),
   // each subtracting and xoring a rotated copy of one word and then adding
   // the third word into that rotated source. Unused step codes hold state.
   always_comb begin
      a_next = a;
      b_next = b;
      c_next = c;
      case (step)
         3'd0: begin
            a_next = (a - c) ^ rotl(c, ROT_AMT[0]);
            c_next = c + b;
         end
         3'd1: begin
            b_next = (b - a) ^ rotl(a, ROT_AMT[1]);
            a_next = a + c;
         end
         3'd2: begin
            c_next = (c - b) ^ rotl(b, ROT_AMT[2]);
            b_next = b + a;
         end
         3'd3: begin
            a_next = (a - c) ^ rotl(c, ROT_AMT[3]);
            c_next = c + b;
         end
         3'd4: begin
            b_next = (b - a) ^ rotl(a, ROT_AMT[4]);
            a_next = a + c;
         end
         3'd5: begin
            c_next = (c - b) ^ rotl(b, ROT_AMT[5]);
            b_next = b + a;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/lookup3_block_mixer.sv
// lookup3_block_mixer
// Front half of lookup3 hashlittle: initialises a/b/c from the key length
// and seed, folds and mixes every 12-byte block except the last, then
// presents the mixed state, the zero-padded last block and its byte count.
// Ports:
//   clk, res              : clock, synchronous active-high reset
//   start, length         : begin a hash of 'length' bytes (IDLE only)
//   busy                  : controller is not idle
//   in_valid/in_ready     : key word handshake, in_data little-endian
//   out_valid/out_ready   : hand-off handshake
//   out_a/out_b/out_c     : state after all non-final blocks
//   out_k0/out_k1/out_k2  : last-block words, bytes past the key zeroed
//   out_tail              : byte count of the last block, 0..12
module lookup3_block_mixer
   import lookup3_pkg::*;
#(
   parameter logic [31:0] INITVAL = 32'h0
)
(
   input  logic        clk,
   input  logic        res,
   input  logic        start,
   input  logic [31:0] length,
   output logic        busy,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_a,
   output logic [31:0] out_b,
   output logic [31:0] out_c,
   output logic [31:0] out_k0,
   output logic [31:0] out_k1,
   output logic [31:0] out_k2,
   output logic [3:0]  out_tail
);

   state_t      state;
   logic [31:0] a, b, c;
   logic [31:0] k0, k1, k2;
   logic [31:0] rem;
   logic [1:0]  idx;
   logic [2:0]  step;
   logic [3:0]  tail;

   logic [31:0] init_abc;
   logic [3:0]  nb;
   logic [3:0]  nb_minus1;
   logic [1:0]  last_idx;
   logic [31:0] masked;
   logic [31:0] mix_a, mix_b, mix_c;

   assign init_abc = INIT_WORD + length + INITVAL;

   // Bytes belonging to the block being loaded and the slot index of its
   // final word; only meaningful in LOAD where rem is at least 1.
   always_comb begin
      nb        = (rem > 32'(BLOCK_BYTES)) ? 4'(BLOCK_BYTES) : rem[3:0];
      nb_minus1 = nb - 4'd1;
      last_idx  = nb_minus1[3:2];
   end

   // Zero every byte of the incoming word that lies past the end of the
   // key, so garbage in a partial final word never reaches the hash.
   always_comb begin
      masked = '0;
      for (int n = 0; n < 4; n++) begin
         if (({idx, 2'b00} + 4'(n)) < nb) begin
            masked[8*n +: 8] = in_data[8*n +: 8];
         end
      end
   end

   lookup3_mix_step u_mix (
      .a      (a),
      .b      (b),
      .c      (c),
      .step   (step),
      .a_next (mix_a),
      .b_next (mix_b),
      .c_next (mix_c)
   );

   // Controller and datapath registers. LOAD captures up to three words,
   // then either folds and mixes the block (more key follows) or parks in
   // OUT with the block as the hand-off. The mix slots are cleared in ADD
   // so a short final block finds its unfilled words already zero.
   always_ff @(posedge clk) begin
      if (res) begin
         state <= IDLE;
         a     <= '0;
         b     <= '0;
         c     <= '0;
         k0    <= '0;
         k1    <= '0;
         k2    <= '0;
         rem   <= '0;
         idx   <= '0;
         step  <= '0;
         tail  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a    <= init_abc;
                  b    <= init_abc;
                  c    <= init_abc;
                  rem  <= length;
                  k0   <= '0;
                  k1   <= '0;
                  k2   <= '0;
                  idx  <= '0;
                  step <= '0;
                  if (length == 32'd0) begin
                     tail  <= '0;
                     state <= OUT;
                  end else begin
                     state <= LOAD;
                  end
               end
            end
            LOAD: begin
               if (in_valid) begin
                  case (idx)
                     2'd0:    k0 <= masked;
                     2'd1:    k1 <= masked;
                     default: k2 <= masked;
                  endcase
                  if (idx == last_idx) begin
                     if (rem > 32'(BLOCK_BYTES)) begin
                        state <= ADD;
                     end else begin
                        tail  <= nb;
                        state <= OUT;
                     end
                  end else begin
                     idx <= idx + 2'd1;
                  end
               end
            end
            ADD: begin
               a     <= a + k0;
               b     <= b + k1;
               c     <= c + k2;
               rem   <= rem - 32'(BLOCK_BYTES);
               k0    <= '0;
               k1    <= '0;
               k2    <= '0;
               idx   <= '0;
               step  <= '0;
               state <= MIX;
            end
            MIX: begin
               a <= mix_a;
               b <= mix_b;
               c <= mix_c;
               if (step == 3'd5) begin
                  state <= LOAD;
               end else begin
                  step <= step + 3'd1;
               end
            end
            OUT: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy      = (state != IDLE);
   assign in_ready  = (state == LOAD);
   assign out_valid = (state == OUT);
   assign out_a     = a;
   assign out_b     = b;
   assign out_c     = c;
   assign out_k0    = k0;
   assign out_k1    = k1;
   assign out_k2    = k2;
   assign out_tail  = tail;

endmodule

// File: tb/tb_lookup3_block_mixer.sv
// tb_lookup3_block_mixer
// Self-checking bench for lookup3_block_mixer. Two instances share all
// inputs: one with INITVAL 0, one with INITVAL 1. Each hash pushes a
// reference result onto a scoreboard queue; the hand-off pops and compares.
module tb_lookup3_block_mixer;

   logic        clk = 1'b0;
   logic        res;
   logic        start;
   logic [31:0] length;
   logic        in_valid;
   logic [31:0] in_data;
   logic        out_ready;

   logic        busy, in_ready, out_valid;
   logic [31:0] out_a, out_b, out_c, out_k0, out_k1, out_k2;
   logic [3:0]  out_tail;

   logic        busy1, in_ready1, out_valid1;
   logic [31:0] out_a1, out_b1, out_c1, out_k01, out_k11, out_k21;
   logic [3:0]  out_tail1;

   typedef struct {
      logic [31:0] a, b, c, k0, k1, k2;
      logic [3:0]  tail;
      logic [31:0] a1, b1, c1;
   } exp_t;

   typedef struct {
      int          len;
      int          mode;
      bit          toggle;
      int          stall;
      bit          spur;
      bit          has_const;
      logic [31:0] ca, ck0, ck1, ck2;
      logic [3:0]  ctail;
   } vec_t;

   exp_t       sb_q[$];
   vec_t       vecs[8];
   logic [7:0] key [0:63];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int acc_cnt = 0;
   int acc_start = 0;
   int words_exp = 0;

   always #5 clk = ~clk;

   lookup3_block_mixer #(.INITVAL(32'h0)) dut (
      .clk(clk), .res(res), .start(start), .length(length), .busy(busy),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_a(out_a), .out_b(out_b), .out_c(out_c),
      .out_k0(out_k0), .out_k1(out_k1), .out_k2(out_k2), .out_tail(out_tail)
   );

   lookup3_block_mixer #(.INITVAL(32'h1)) dut1 (
      .clk(clk), .res(res), .start(start), .length(length), .busy(busy1),
      .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
      .out_valid(out_valid1), .out_ready(out_ready),
      .out_a(out_a1), .out_b(out_b1), .out_c(out_c1),
      .out_k0(out_k01), .out_k1(out_k11), .out_k2(out_k21), .out_tail(out_tail1)
   );

   // Free-running cycle count and accepted-word count of the INITVAL 0 DUT.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (in_valid && in_ready) acc_cnt <= acc_cnt + 1;
   end

   // Guard against a hung run.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] rot(input logic [31:0] x, input int k);
      return (x << k) | (x >> (32 - k));
   endfunction

   function automatic logic [31:0] key_word(input int p);
      return {key[p+3], key[p+2], key[p+1], key[p]};
   endfunction

   // Reference hashlittle front half over the key byte array.
   function automatic void ref_abc(input int len, input logic [31:0] iv,
                                   output logic [31:0] ra, output logic [31:0] rb,
                                   output logic [31:0] rc);
      logic [31:0] a, b, c;
      int rem, p;
      a = 32'hDEADBEEF + 32'(len) + iv;
      b = a;
      c = a;
      rem = len;
      p = 0;
      while (rem > 12) begin
         a += key_word(p);
         b += key_word(p + 4);
         c += key_word(p + 8);
         a -= c; a ^= rot(c, 4);  c += b;
         b -= a; b ^= rot(a, 6);  a += c;
         c -= b; c ^= rot(b, 8);  b += a;
         a -= c; a ^= rot(c, 16); c += b;
         b -= a; b ^= rot(a, 19); a += c;
         c -= b; c ^= rot(b, 4);  b += a;
         rem -= 12;
         p += 12;
      end
      ra = a;
      rb = b;
      rc = c;
   endfunction

   function automatic exp_t model(input int len);
      exp_t e;
      int rem, p;
      ref_abc(len, 32'h0, e.a, e.b, e.c);
      ref_abc(len, 32'h1, e.a1, e.b1, e.c1);
      p = (len == 0) ? 0 : 12 * ((len - 1) / 12);
      rem = len - p;
      e.k0 = '0;
      e.k1 = '0;
      e.k2 = '0;
      for (int i = 0; i < rem; i++) begin
         case (i / 4)
            0:       e.k0[8*(i%4) +: 8] = key[p+i];
            1:       e.k1[8*(i%4) +: 8] = key[p+i];
            default: e.k2[8*(i%4) +: 8] = key[p+i];
         endcase
      end
      e.tail = 4'(rem);
      return e;
   endfunction

   task automatic fillKey(input int mode, input int len);
      for (int i = 0; i < 64; i++) key[i] = 8'($urandom);
      if (mode == 0) begin
         key[0] = 8'h68; key[1] = 8'h65; key[2] = 8'h6C; key[3] = 8'h6C; key[4] = 8'h6F;
      end else if (mode == 1) begin
         for (int i = 0; i < len; i++) key[i] = 8'h61 + 8'(i);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      exp_t e;
      int w, guard, start_cyc, nonfinal, nb, lat_exp;
      bit hs;
      fillKey(v.mode, v.len);
      e = model(v.len);
      sb_q.push_back(e);
      words_exp = (v.len + 3) / 4;
      acc_start = acc_cnt;
      nonfinal = (v.len == 0) ? 0 : (v.len - 1) / 12;
      nb = v.len - 12 * nonfinal;
      lat_exp = 1 + 10 * nonfinal + (nb + 3) / 4;
      start = 1'b1;
      length = 32'(v.len);
      start_cyc = cyc;
      @(posedge clk); #1;
      start = v.spur;
      length = 32'd3;
      w = 0;
      guard = 0;
      while (w < words_exp && guard < 1000) begin
         in_valid = v.toggle ? 1'($urandom_range(0, 1)) : 1'b1;
         in_data = key_word(4 * w);
         hs = in_valid && in_ready;
         @(posedge clk); #1;
         if (hs) w++;
         guard++;
      end
      check("words_fed", 32'(w), 32'(words_exp));
      in_valid = 1'b1;
      in_data = 32'hBAD0BAD0;
      guard = 0;
      while (!out_valid && guard < 500) begin
         @(posedge clk); #1;
         guard++;
      end
      check("out_valid_seen", 32'(out_valid), 32'd1);
      if (!v.toggle) check("latency", 32'(cyc - start_cyc), 32'(lat_exp));
   endtask

   task automatic compareAll(input exp_t e);
      check("out_valid", 32'(out_valid), 32'd1);
      check("out_a", out_a, e.a);
      check("out_b", out_b, e.b);
      check("out_c", out_c, e.c);
      check("out_k0", out_k0, e.k0);
      check("out_k1", out_k1, e.k1);
      check("out_k2", out_k2, e.k2);
      check("out_tail", 32'(out_tail), 32'(e.tail));
      check("iv1_out_valid", 32'(out_valid1), 32'd1);
      check("iv1_out_a", out_a1, e.a1);
      check("iv1_out_b", out_b1, e.b1);
      check("iv1_out_c", out_c1, e.c1);
      check("iv1_out_k0", out_k01, e.k0);
      check("iv1_out_tail", 32'(out_tail1), 32'(e.tail));
   endtask

   task automatic checkOutput(input vec_t v);
      exp_t e;
      checks++;
      if (sb_q.size() == 0) begin
         errors++;
         $display("[TB] FAIL scoreboard: got empty queue required one entry");
         return;
      end
      e = sb_q.pop_front();
      for (int s = 0; s <= v.stall; s++) begin
         compareAll(e);
         if (s < v.stall) begin
            @(posedge clk); #1;
         end
      end
      if (v.has_const) begin
         check("const_a", out_a, v.ca);
         check("const_k0", out_k0, v.ck0);
         check("const_k1", out_k1, v.ck1);
         check("const_k2", out_k2, v.ck2);
         check("const_tail", 32'(out_tail), 32'(v.ctail));
         check("const_iv1_a", out_a1, v.ca + 32'd1);
      end
      start = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid = 1'b0;
      check("out_valid_drop", 32'(out_valid), 32'd0);
      check("busy_idle", 32'(busy), 32'd0);
      check("words_accepted", 32'(acc_cnt - acc_start), 32'(words_exp));
   endtask

   task automatic checkIdleZero(input string tag);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
      check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_out_a"}, out_a, 32'd0);
      check({tag, "_out_b"}, out_b, 32'd0);
      check({tag, "_out_c"}, out_c, 32'd0);
      check({tag, "_out_k0"}, out_k0, 32'd0);
      check({tag, "_out_k1"}, out_k1, 32'd0);
      check({tag, "_out_k2"}, out_k2, 32'd0);
      check({tag, "_out_tail"}, 32'(out_tail), 32'd0);
      check({tag, "_iv1_out_a"}, out_a1, 32'd0);
   endtask

   initial begin
      vecs[0] = '{0,  1, 1'b0, 0, 1'b0, 1'b1, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 4'd0};
      vecs[1] = '{5,  0, 1'b0, 2, 1'b0, 1'b1, 32'hDEADBEF4, 32'h6C6C6568, 32'h0000006F, 32'h0, 4'd5};
      vecs[2] = '{12, 1, 1'b0, 0, 1'b0, 1'b1, 32'hDEADBEFB, 32'h64636261, 32'h68676665, 32'h6C6B6A69, 4'd12};
      vecs[3] = '{25, 2, 1'b1, 5, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 4'd0};
      vecs[4] = '{24, 2, 1'b0, 1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 4'd0};
      vecs[5] = '{13, 2, 1'b0, 0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 4'd0};
      vecs[6] = '{36, 2, 1'b0, 0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 4'd0};
      vecs[7] = '{7,  2, 1'b1, 0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 4'd0};

      res = 1'b1;
      start = 1'b0;
      length = '0;
      in_valid = 1'b0;
      in_data = '0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      res = 1'b0;
      checkIdleZero("reset");

      for (int i = 0; i < 8; i++) begin
         $display("[TB] vector %0d: length %0d", i, vecs[i].len);
         applyStimulus(vecs[i]);
         checkOutput(vecs[i]);
      end

      $display("[TB] reset during MIX of a 30-byte hash");
      fillKey(2, 30);
      start = 1'b1;
      length = 32'd30;
      @(posedge clk); #1;
      start = 1'b0;
      in_valid = 1'b1;
      for (int w = 0; w < 3; w++) begin
         in_data = key_word(4 * w);
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      @(posedge clk); #1;
      res = 1'b1;
      @(posedge clk); #1;
      res = 1'b0;
      in_valid = 1'b0;
      checkIdleZero("mid_mix_reset");

      applyStimulus(vecs[2]);
      checkOutput(vecs[2]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
